// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the hazard/stall sequencer of the RV32 core.
package hazard_ctrl_unit_pkg;

    // Default register-address width of the RV32 integer register file
    localparam int HZ_REG_AW = 5;

    // Sequencer states: normal flow, multi-cycle data stall, memory wait
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        MWAIT  = 2'd2
    } hz_state_t;

    // Number of stall cycles a RAW hazard requires (0, 1 or 2)
    typedef logic [1:0] hz_nstall_t;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-info and stall-control bundle between the core and the hazard unit.
interface hazard_ctrl_unit_if
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW,
    parameter int PERF_W = 32
);
    // ID stage consumer
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              id_is_branch;
    // EX stage producer
    logic              ex_valid;
    logic              ex_rd_we;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    // MEM stage producer
    logic              mem_valid;
    logic              mem_rd_we;
    logic              mem_is_load;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_access;
    // Control transfer resolution
    logic              mispredict;
    // Pipeline controls
    logic              pc_en;
    logic              fd_en;
    logic              de_en;
    logic              em_en;
    logic              mw_en;
    logic              fd_flush;
    logic              de_bubble;
    logic              mw_bubble;
    logic [PERF_W-1:0] stall_cycles;
    logic [1:0]        state_o;

    // Pipeline side: supplies stage info, consumes the controls
    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_branch,
        output ex_valid, ex_rd_we, ex_is_load, ex_rd,
        output mem_valid, mem_rd_we, mem_is_load, mem_rd, mem_access,
        output mispredict,
        input  pc_en, fd_en, de_en, em_en, mw_en,
        input  fd_flush, de_bubble, mw_bubble, stall_cycles, state_o
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_branch,
        input  ex_valid, ex_rd_we, ex_is_load, ex_rd,
        input  mem_valid, mem_rd_we, mem_is_load, mem_rd, mem_access,
        input  mispredict,
        output pc_en, fd_en, de_en, em_en, mw_en,
        output fd_flush, de_bubble, mw_bubble, stall_cycles, state_o
    );

endinterface

// File: rtl/hazard_ctrl_unit_raw_detect.sv
// Combinational RAW hazard detection: finds producer/consumer register
// matches and converts them into the number of stall cycles ID must wait.
module hz_raw_detect
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW,
    parameter int FWD_EN = 1
) (
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic              id_is_branch_i,
    input  logic              ex_valid_i,
    input  logic              ex_rd_we_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              mem_valid_i,
    input  logic              mem_rd_we_i,
    input  logic              mem_is_load_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    output hz_nstall_t        n_o
);

    // True when a live producer writing rd feeds either used source of ID
    function automatic logic src_match(
        input logic              prod_valid,
        input logic              prod_we,
        input logic [REG_AW-1:0] prod_rd,
        input logic              cons_valid,
        input logic [REG_AW-1:0] rs1,
        input logic              rs1_used,
        input logic [REG_AW-1:0] rs2,
        input logic              rs2_used
    );
        logic hit;
        hit = (rs1_used && (rs1 == prod_rd)) || (rs2_used && (rs2 == prod_rd));
        return prod_valid && prod_we && (prod_rd != '0) && cons_valid && hit;
    endfunction

    logic ex_match;
    logic mem_match;

    // Match each producer stage against the ID sources and derive the stall count
    always_comb begin
        ex_match  = src_match(ex_valid_i, ex_rd_we_i, ex_rd_i, id_valid_i,
                              id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i);
        mem_match = src_match(mem_valid_i, mem_rd_we_i, mem_rd_i, id_valid_i,
                              id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i);
        n_o = 2'd0;
        if (FWD_EN != 0) begin
            // Forwarding covers ALU results for EX; only loads and ID-side
            // compares still need to wait.
            if (ex_match && ex_is_load_i) begin
                n_o = id_is_branch_i ? 2'd2 : 2'd1;
            end else if (ex_match && id_is_branch_i) begin
                n_o = 2'd1;
            end else if (mem_match && mem_is_load_i && id_is_branch_i) begin
                n_o = 2'd1;
            end
        end else begin
            // Without forwarding the value only appears via the regfile in WB
            if (ex_match) begin
                n_o = 2'd2;
            end else if (mem_match) begin
                n_o = 2'd1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard-detection and stall sequencer for the 5-stage RV32 pipeline.
// Drives PC/pipeline-register enables, flush and bubble controls, and keeps
// a saturating count of cycles in which the PC was held.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_AW  = HZ_REG_AW,
    parameter int FWD_EN  = 1,
    parameter int MEM_LAT = 2,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_unit_if.slave bus
);

    localparam int              MCNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);
    localparam bit              MEM_STALL_EN = (MEM_LAT > 0);
    localparam bit              MEM_MULTI    = (MEM_LAT > 1);

    // Saturating increment for the performance counter
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    hz_state_t         state_q, state_d;
    logic [1:0]        dcnt_q, dcnt_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic              mem_done_q, mem_done_d;
    logic [PERF_W-1:0] perf_q, perf_d;

    hz_nstall_t        n_req;
    logic              mem_req;
    logic [1:0]        dcnt_dec;
    logic [MCNT_W-1:0] mcnt_dec;

    logic pc_en, fd_en, de_en, em_en, mw_en;
    logic fd_flush, de_bubble, mw_bubble;

    hz_raw_detect #(
        .REG_AW (REG_AW),
        .FWD_EN (FWD_EN)
    ) u_raw_detect (
        .id_valid_i     (bus.id_valid),
        .id_rs1_i       (bus.id_rs1),
        .id_rs2_i       (bus.id_rs2),
        .id_rs1_used_i  (bus.id_rs1_used),
        .id_rs2_used_i  (bus.id_rs2_used),
        .id_is_branch_i (bus.id_is_branch),
        .ex_valid_i     (bus.ex_valid),
        .ex_rd_we_i     (bus.ex_rd_we),
        .ex_is_load_i   (bus.ex_is_load),
        .ex_rd_i        (bus.ex_rd),
        .mem_valid_i    (bus.mem_valid),
        .mem_rd_we_i    (bus.mem_rd_we),
        .mem_is_load_i  (bus.mem_is_load),
        .mem_rd_i       (bus.mem_rd),
        .n_o            (n_req)
    );

    // Next-state, counter and output decode; priority is reset, memory
    // stall, mispredict, then data stall.
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        mcnt_d     = mcnt_q;
        mem_done_d = 1'b0;
        pc_en      = 1'b1;
        fd_en      = 1'b1;
        de_en      = 1'b1;
        em_en      = 1'b1;
        mw_en      = 1'b1;
        fd_flush   = 1'b0;
        de_bubble  = 1'b0;
        mw_bubble  = 1'b0;
        dcnt_dec   = dcnt_q - 2'd1;
        mcnt_dec   = mcnt_q - MCNT_W'(1);
        // The access that just finished waiting is still in MEM for one
        // more cycle; it must advance rather than restart the wait.
        mem_req    = MEM_STALL_EN && bus.mem_access && !mem_done_q;

        if (rst) begin
            state_d = RUN;
            dcnt_d  = '0;
            mcnt_d  = '0;
        end else if (state_q == MWAIT) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_en     = 1'b0;
            em_en     = 1'b0;
            mw_en     = 1'b0;
            mw_bubble = 1'b1;
            mcnt_d    = mcnt_dec;
            if (mcnt_dec == '0) begin
                state_d    = RUN;
                mem_done_d = 1'b1;
            end
        end else if (mem_req) begin
            // Entry cycle of a memory stall counts as the first wait cycle
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_en     = 1'b0;
            em_en     = 1'b0;
            mw_en     = 1'b0;
            mw_bubble = 1'b1;
            mcnt_d    = MCNT_INIT;
            if (MEM_MULTI) begin
                state_d = MWAIT;
            end else begin
                state_d    = RUN;
                mem_done_d = 1'b1;
            end
        end else if (bus.mispredict) begin
            // ID holds a wrong-path instruction, so any pending data stall is moot
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            state_d   = RUN;
            dcnt_d    = '0;
        end else if (state_q == DSTALL) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
            dcnt_d    = dcnt_dec;
            if (dcnt_dec == 2'd0) begin
                state_d = RUN;
            end
        end else if (n_req != 2'd0) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
            if (n_req == 2'd2) begin
                state_d = DSTALL;
                dcnt_d  = 2'd1;
            end
        end

        perf_d = pc_en ? perf_q : sat_inc(perf_q);
    end

    // State, counters and performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            dcnt_q     <= '0;
            mcnt_q     <= '0;
            mem_done_q <= 1'b0;
            perf_q     <= '0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            mcnt_q     <= mcnt_d;
            mem_done_q <= mem_done_d;
            perf_q     <= perf_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.fd_en        = fd_en;
    assign bus.de_en        = de_en;
    assign bus.em_en        = em_en;
    assign bus.mw_en        = mw_en;
    assign bus.fd_flush     = fd_flush;
    assign bus.de_bubble    = de_bubble;
    assign bus.mw_bubble    = mw_bubble;
    assign bus.stall_cycles = perf_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios followed by random stimulus,
// every cycle compared against a remaining-cycles reference model.
module tb_hazard_ctrl_unit;
    import hazard_ctrl_unit_pkg::*;

    localparam int REG_AW  = 5;
    localparam int FWD_EN  = 1;
    localparam int MEM_LAT = 3;
    localparam int PERF_W  = 4;

    localparam logic [7:0] CTL_RUN  = 8'b11111_000;
    localparam logic [7:0] CTL_DST  = 8'b00111_010;
    localparam logic [7:0] CTL_MEM  = 8'b00000_001;
    localparam logic [7:0] CTL_FLSH = 8'b11111_110;

    logic clk = 1'b0;
    logic rst;

    hazard_ctrl_unit_if #(.REG_AW(REG_AW), .PERF_W(PERF_W)) hz_if ();

    hazard_ctrl_unit #(
        .REG_AW  (REG_AW),
        .FWD_EN  (FWD_EN),
        .MEM_LAT (MEM_LAT),
        .PERF_W  (PERF_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (hz_if.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cycles still owed to each kind of stall
    int              m_mem_left  = 0;
    int              m_data_left = 0;
    bit              m_skip      = 1'b0;
    logic [PERF_W-1:0] m_perf    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [7:0] ctl_now();
        return {hz_if.pc_en, hz_if.fd_en, hz_if.de_en, hz_if.em_en, hz_if.mw_en,
                hz_if.fd_flush, hz_if.de_bubble, hz_if.mw_bubble};
    endfunction

    // Stall cycles demanded by the RAW rules for the present inputs
    function automatic int need_n();
        bit ex_m, mem_m, br;
        int n;
        ex_m  = hz_if.id_valid && hz_if.ex_valid && hz_if.ex_rd_we && (hz_if.ex_rd != 0) &&
                ((hz_if.id_rs1_used && hz_if.id_rs1 == hz_if.ex_rd) ||
                 (hz_if.id_rs2_used && hz_if.id_rs2 == hz_if.ex_rd));
        mem_m = hz_if.id_valid && hz_if.mem_valid && hz_if.mem_rd_we && (hz_if.mem_rd != 0) &&
                ((hz_if.id_rs1_used && hz_if.id_rs1 == hz_if.mem_rd) ||
                 (hz_if.id_rs2_used && hz_if.id_rs2 == hz_if.mem_rd));
        br = hz_if.id_is_branch;
        n  = 0;
        if (FWD_EN != 0) begin
            if (ex_m && hz_if.ex_is_load) n = br ? 2 : 1;
            if (ex_m && !hz_if.ex_is_load && br && n < 1) n = 1;
            if (mem_m && hz_if.mem_is_load && br && n < 1) n = 1;
        end else begin
            if (mem_m) n = 1;
            if (ex_m) n = 2;
        end
        return n;
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic step();
        logic [7:0] exp_ctl;
        logic [1:0] exp_st;
        int nx_mem, nx_data, n;
        bit nx_skip;
        @(negedge clk);
        exp_st  = (m_mem_left > 0) ? 2'(MWAIT) : (m_data_left > 0) ? 2'(DSTALL) : 2'(RUN);
        nx_mem  = m_mem_left;
        nx_data = m_data_left;
        nx_skip = 1'b0;
        if (rst) begin
            exp_ctl = CTL_RUN;
            nx_mem  = 0;
            nx_data = 0;
        end else if (m_mem_left > 0) begin
            exp_ctl = CTL_MEM;
            nx_mem  = m_mem_left - 1;
            nx_skip = (nx_mem == 0);
        end else if (hz_if.mem_access && MEM_LAT > 0 && !m_skip) begin
            exp_ctl = CTL_MEM;
            nx_mem  = MEM_LAT - 1;
            nx_skip = (nx_mem == 0);
            nx_data = 0;
        end else if (hz_if.mispredict) begin
            exp_ctl = CTL_FLSH;
            nx_data = 0;
        end else if (m_data_left > 0) begin
            exp_ctl = CTL_DST;
            nx_data = m_data_left - 1;
        end else begin
            n = need_n();
            exp_ctl = (n > 0) ? CTL_DST : CTL_RUN;
            nx_data = (n > 0) ? n - 1 : 0;
        end
        chk("ctl", 32'(ctl_now()), 32'(exp_ctl));
        chk("state", 32'(hz_if.state_o), 32'(exp_st));
        chk("stall_cycles", 32'(hz_if.stall_cycles), 32'(m_perf));
        @(posedge clk);
        if (rst) m_perf = '0;
        else if (!exp_ctl[7] && m_perf != '1) m_perf = m_perf + 1'b1;
        m_mem_left  = nx_mem;
        m_data_left = nx_data;
        m_skip      = nx_skip;
        #1;
    endtask

    task automatic clr_in();
        hz_if.id_valid = 0; hz_if.id_rs1 = '0; hz_if.id_rs2 = '0;
        hz_if.id_rs1_used = 0; hz_if.id_rs2_used = 0; hz_if.id_is_branch = 0;
        hz_if.ex_valid = 0; hz_if.ex_rd_we = 0; hz_if.ex_is_load = 0; hz_if.ex_rd = '0;
        hz_if.mem_valid = 0; hz_if.mem_rd_we = 0; hz_if.mem_is_load = 0; hz_if.mem_rd = '0;
        hz_if.mem_access = 0; hz_if.mispredict = 0;
    endtask

    // EX: lw x5; ID: consumer of x5 (branch form compares x5 with x0)
    task automatic set_ldu(input bit branch);
        clr_in();
        hz_if.ex_valid = 1; hz_if.ex_rd_we = 1; hz_if.ex_is_load = 1; hz_if.ex_rd = 5'd5;
        hz_if.id_valid = 1; hz_if.id_rs1 = 5'd5; hz_if.id_rs2 = branch ? 5'd0 : 5'd1;
        hz_if.id_rs1_used = 1; hz_if.id_rs2_used = 1; hz_if.id_is_branch = branch;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        step();  // reset cycle, checked against the model
        rst = 0;

        // Load-use, ALU consumer: single stall
        set_ldu(0); step();
        clr_in(); step();
        chk("ldu_count", 32'(hz_if.stall_cycles), 32'd1);

        // Load-use feeding an ID-side compare: two stalls via DSTALL
        do_reset();
        set_ldu(1); step();
        chk("ldbr_dstall", 32'(hz_if.state_o), 32'(DSTALL));
        step();
        chk("ldbr_run", 32'(hz_if.state_o), 32'(RUN));
        clr_in(); step();
        chk("ldbr_count", 32'(hz_if.stall_cycles), 32'd2);

        // x0 is never a hazard
        clr_in();
        hz_if.ex_valid = 1; hz_if.ex_rd_we = 1; hz_if.ex_is_load = 1; hz_if.ex_rd = 5'd0;
        hz_if.id_valid = 1; hz_if.id_rs1_used = 1; hz_if.id_rs2_used = 1;
        #1;
        chk("x0_en", 32'(ctl_now()), 32'(CTL_RUN));
        step();

        // Store held in MEM for MEM_LAT cycles, then advances
        do_reset();
        clr_in(); hz_if.mem_valid = 1; hz_if.mem_access = 1;
        repeat (3) step();
        chk("mem_adv_em", 32'(hz_if.em_en), 32'd1);
        step();
        clr_in(); step();
        chk("mem_count", 32'(hz_if.stall_cycles), 32'd3);

        // Mispredict beats a load-use hazard
        set_ldu(1); hz_if.mispredict = 1; #1;
        chk("mp_flush", 32'({hz_if.pc_en, hz_if.fd_flush, hz_if.de_bubble}), 32'b111);
        step();
        chk("mp_state", 32'(hz_if.state_o), 32'(RUN));

        // Mispredict held through a memory wait is taken on exit
        clr_in(); hz_if.mem_access = 1; step();
        hz_if.mispredict = 1; #1;
        chk("mp_mwait_ign", 32'(hz_if.fd_flush), 32'd0);
        step(); step();
        #1;
        chk("mp_mwait_exit", 32'(hz_if.fd_flush), 32'd1);
        step();

        // Reset in the middle of DSTALL
        set_ldu(1); step();
        rst = 1; step(); rst = 0; clr_in(); #1;
        chk("rst_ds_state", 32'(hz_if.state_o), 32'(RUN));
        chk("rst_ds_cnt", 32'(hz_if.stall_cycles), 32'd0);
        chk("rst_ds_en", 32'(ctl_now()), 32'(CTL_RUN));
        step();

        // Reset in the middle of MWAIT
        clr_in(); hz_if.mem_access = 1; step(); step();
        rst = 1; step(); rst = 0; clr_in(); #1;
        chk("rst_mw_state", 32'(hz_if.state_o), 32'(RUN));
        chk("rst_mw_cnt", 32'(hz_if.stall_cycles), 32'd0);
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst                = ($urandom_range(0, 59) == 0);
            hz_if.id_valid     = ($urandom_range(0, 3) != 0);
            hz_if.id_rs1       = REG_AW'($urandom_range(0, 3));
            hz_if.id_rs2       = REG_AW'($urandom_range(0, 3));
            hz_if.id_rs1_used  = 1'($urandom);
            hz_if.id_rs2_used  = 1'($urandom);
            hz_if.id_is_branch = ($urandom_range(0, 2) == 0);
            hz_if.ex_valid     = ($urandom_range(0, 3) != 0);
            hz_if.ex_rd_we     = 1'($urandom);
            hz_if.ex_is_load   = 1'($urandom);
            hz_if.ex_rd        = REG_AW'($urandom_range(0, 3));
            hz_if.mem_valid    = ($urandom_range(0, 3) != 0);
            hz_if.mem_rd_we    = 1'($urandom);
            hz_if.mem_is_load  = 1'($urandom);
            hz_if.mem_rd       = REG_AW'($urandom_range(0, 3));
            hz_if.mem_access   = ($urandom_range(0, 5) == 0);
            hz_if.mispredict   = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
